// File: rtl/dpram_ctl.sv
// dpram_ctl: true dual-port synchronous RAM with a clear sweep after reset, per-port read-valid
// strobes, selectable read latency and a saturating write-collision counter. Parity: DPRAM_PARITY_EN.
module dpram_ctl #(
    parameter int W           = 16,
    parameter int AW          = 8,
    parameter int DEPTH       = 256,
    parameter int RD_LAT      = 1,
    parameter int WRITE_FIRST = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          a_en,
    input  logic          a_we,
    input  logic [AW-1:0] a_addr,
    input  logic [W-1:0]  a_wdata,
    output logic [W-1:0]  a_rdata,
    output logic          a_rvalid,
    input  logic          b_en,
    input  logic          b_we,
    input  logic [AW-1:0] b_addr,
    input  logic [W-1:0]  b_wdata,
    output logic [W-1:0]  b_rdata,
    output logic          b_rvalid,
    output logic          busy,
    output logic          collision,
    output logic [7:0]    coll_cnt,
`ifdef DPRAM_PARITY_EN
    output logic          a_perr,
    output logic          b_perr,
`endif
    output logic          dbg_state
);

    // Port protocol: en is a single-cycle request with no backpressure (always accepted in RUN,
    // silently ignored while busy); every accepted read yields exactly one rvalid pulse RD_LAT edges later.
    typedef enum logic {ST_CLEAR, ST_RUN} state_e;

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
    localparam logic [AW:0]   DEPTH_LIM = (AW + 1)'(DEPTH);

    state_e        state_q, state_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic          busy_q, busy_d;
    logic          coll_q;
    logic [7:0]    cnt_q, cnt_d;

    logic [W-1:0]  mem_q [DEPTH];

    logic          run, a_in, b_in, same_addr;
    logic          a_wr, b_wr, a_rd, b_rd, coll;
    logic          a_wr_ok, b_wr_ok, a_byp, b_byp;
    logic [W-1:0]  a_rd_data, b_rd_data;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            ST_CLEAR: begin
                ptr_d = ptr_q + 1'b1;
                if (ptr_q == LAST_ADDR) begin
                    state_d = ST_RUN;
                    ptr_d   = '0;
                end
            end
            ST_RUN: ;
            default: state_d = ST_CLEAR;
        endcase
        busy_d = (state_d == ST_CLEAR);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_CLEAR;
            ptr_q   <= '0;
            busy_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            busy_q  <= busy_d;
        end
    end

    assign run       = (state_q == ST_RUN);
    assign a_in      = ({1'b0, a_addr} < DEPTH_LIM);
    assign b_in      = ({1'b0, b_addr} < DEPTH_LIM);
    assign same_addr = (a_addr == b_addr);
    assign a_wr      = run & a_en & a_we;
    assign b_wr      = run & b_en & b_we;
    assign a_rd      = run & a_en & ~a_we;
    assign b_rd      = run & b_en & ~b_we;
    assign coll      = a_wr & b_wr & same_addr;
    assign a_wr_ok   = a_wr & a_in;
    assign b_wr_ok   = b_wr & b_in & ~coll;

    // Cross-port forwarding: a reader sees the other port's same-cycle write only in write-first mode.
    assign a_byp = (WRITE_FIRST != 0) & b_wr_ok & same_addr;
    assign b_byp = (WRITE_FIRST != 0) & a_wr_ok & same_addr;

    always_comb begin
        a_rd_data = '0;
        b_rd_data = '0;
        if (a_in) a_rd_data = a_byp ? b_wdata : mem_q[a_addr];
        if (b_in) b_rd_data = b_byp ? a_wdata : mem_q[b_addr];
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (!run) begin
                mem_q[ptr_q] <= '0;
            end else begin
                if (a_wr_ok) mem_q[a_addr] <= a_wdata;
                if (b_wr_ok) mem_q[b_addr] <= b_wdata;
            end
        end
    end

`ifdef DPRAM_PARITY_EN
    logic par_q [DEPTH];
    logic a_rd_perr, b_rd_perr;
    logic [1:0] pe1_q;
    logic [1:0] pe_out;

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (!run) begin
                par_q[ptr_q] <= 1'b0;
            end else begin
                if (a_wr_ok) par_q[a_addr] <= ^a_wdata;
                if (b_wr_ok) par_q[b_addr] <= ^b_wdata;
            end
        end
    end

    // Forwarded data carries freshly computed parity, so it can never flag an error.
    always_comb begin
        a_rd_perr = 1'b0;
        b_rd_perr = 1'b0;
        if (a_in && !a_byp) a_rd_perr = par_q[a_addr] ^ (^mem_q[a_addr]);
        if (b_in && !b_byp) b_rd_perr = par_q[b_addr] ^ (^mem_q[b_addr]);
    end

    always_ff @(posedge clk) begin
        if (rst) pe1_q <= '0;
        else     pe1_q <= {b_rd & b_rd_perr, a_rd & a_rd_perr};
    end

    assign a_perr = pe_out[0];
    assign b_perr = pe_out[1];
`endif

    logic [1:0]   rv1_q;
    logic [W-1:0] ard1_q, brd1_q;
    logic [1:0]   rv_out;
    logic [W-1:0] ard_out, brd_out;

    always_ff @(posedge clk) begin
        if (rst) begin
            rv1_q  <= '0;
            ard1_q <= '0;
            brd1_q <= '0;
        end else begin
            rv1_q <= {b_rd, a_rd};
            if (a_rd) ard1_q <= a_rd_data;
            if (b_rd) brd1_q <= b_rd_data;
        end
    end

    generate
        if (RD_LAT == 2) begin : g_lat2
            logic [1:0]   rv2_q;
            logic [W-1:0] ard2_q, brd2_q;
            always_ff @(posedge clk) begin
                if (rst) begin
                    rv2_q  <= '0;
                    ard2_q <= '0;
                    brd2_q <= '0;
                end else begin
                    rv2_q <= rv1_q;
                    if (rv1_q[0]) ard2_q <= ard1_q;
                    if (rv1_q[1]) brd2_q <= brd1_q;
                end
            end
            assign rv_out  = rv2_q;
            assign ard_out = ard2_q;
            assign brd_out = brd2_q;
`ifdef DPRAM_PARITY_EN
            logic [1:0] pe2_q;
            always_ff @(posedge clk) begin
                if (rst) pe2_q <= '0;
                else     pe2_q <= pe1_q;
            end
            assign pe_out = pe2_q;
`endif
        end else begin : g_lat1
            assign rv_out  = rv1_q;
            assign ard_out = ard1_q;
            assign brd_out = brd1_q;
`ifdef DPRAM_PARITY_EN
            assign pe_out = pe1_q;
`endif
        end
    endgenerate

    always_comb begin
        cnt_d = cnt_q;
        if (coll && cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            coll_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            coll_q <= coll;
            cnt_q  <= cnt_d;
        end
    end

    assign a_rdata   = ard_out;
    assign b_rdata   = brd_out;
    assign a_rvalid  = rv_out[0];
    assign b_rvalid  = rv_out[1];
    assign busy      = busy_q;
    assign collision = coll_q;
    assign coll_cnt  = cnt_q;
    assign dbg_state = (state_q == ST_RUN);

endmodule

// File: doc/dpram_ctl.md
Name: dpram_ctl

Overview:
- Parametrised true dual-port synchronous RAM; next generation of the data-memory dual-port block.
- Adds a synchronous clear-on-reset sweep with a busy flag, and per-port read-valid strobes.
- Adds selectable read latency, defined same-address cross-port behaviour, and a saturating write-collision counter.
- Serves as the shared data memory between the CPU datapath (port A) and a second master, e.g. DMA/debug (port B).

Parameters:
- W, 16, data word width in bits
- AW, 8, address width in bits
- DEPTH, 256, number of words; must satisfy DEPTH <= 2**AW
- RD_LAT, 1, read latency in cycles; legal values 1 or 2
- WRITE_FIRST, 1, 1 = cross-port read of an address written the same cycle returns new data; 0 = returns old data

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- a_en  in  1  port A access request
- a_we  in  1  port A write (1) / read (0); valid with a_en
- a_addr  in  AW  port A address
- a_wdata  in  W  port A write data
- a_rdata  out  W  port A read data
- a_rvalid  out  1  port A read data valid, one-cycle pulse
- b_en, b_we, b_addr, b_wdata, b_rdata, b_rvalid  same as port A, for port B
- busy  out  1  clear sweep in progress; all accesses are ignored while high
- collision  out  1  one-cycle pulse on a same-address write-write event
- coll_cnt  out  8  saturating count of collisions

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous and active-high.
- Reset values: a_rdata=0, b_rdata=0, a_rvalid=0, b_rvalid=0, busy=1, collision=0, coll_cnt=0, clear pointer=0, FSM=CLEAR.
- FSM has two states: CLEAR and RUN.
- CLEAR: writes 0 to mem[ptr] each cycle, ptr increments 0..DEPTH-1. The cycle that writes DEPTH-1 moves the FSM to RUN; busy falls on the next edge. A DEPTH=256 sweep therefore holds busy high for 256 cycles after rst is released.
- CLEAR port handling: en inputs are ignored; rvalid stays 0; no rdata update.
- rst asserted mid-CLEAR or in RUN: restarts the sweep at ptr=0 and drops in-flight reads; rvalid pipeline is cleared.
- RUN, write: en=1, we=1 writes wdata to mem[addr] at the edge; no rvalid is generated.
- RUN, read: en=1, we=0 samples mem[addr].
  - RD_LAT=1: rdata and rvalid=1 appear after that edge.
  - RD_LAT=2: one extra output register; rvalid follows 2 edges after the request.
- rdata holds its last value when no read completes; rvalid is high for exactly one cycle per read.
- Back-to-back reads, one per cycle per port, at full throughput.
- Out-of-range address (addr >= DEPTH): write is dropped; read returns 0 with rvalid=1.
- Same address, both ports writing: port A data is stored, port B write is dropped. collision=1 for the next cycle; coll_cnt increments, saturating at 255.
- Same address, one port writing and the other reading: the reader gets new data if WRITE_FIRST=1, old data if 0. Not a collision.
- Same address, both ports reading: both get identical data. Not a collision.
- Different addresses: ports are fully independent.
- X/Z on en or we is not filtered; the bench must drive known values.

Optional Feature:
- Macro: DPRAM_PARITY_EN.
- With the macro defined:
  - Each word stores an extra even-parity bit, computed on write and cleared to 0 by the sweep.
  - Ports a_perr and b_perr (1 bit each) are added and assert aligned with rvalid when stored parity mismatches the recomputed parity.
  - Parity bits are held in a separate array to allow error injection.
- Without the macro: no parity storage, and the perr ports do not exist.

Test Plan:
- Reset/clear: rst high 1 cycle with DEPTH=256 -> busy high for 256 cycles then low. Read addr 0x00, 0x7F, 0xFF -> rdata=0x0000, rvalid one cycle later.
- Basic R/W: A writes 0xBEEF @0x10, next cycle B reads 0x10 -> b_rdata=0xBEEF, b_rvalid pulse 1 cycle (RD_LAT=1); repeat with RD_LAT=2 -> valid 2 cycles after request.
- Write-write collision: A writes 0x1111, B writes 0x2222, both @0x20 in the same cycle -> mem[0x20]=0x1111, collision pulse, coll_cnt=1. 300 repeats -> coll_cnt=255.
- Read-during-write: mem[0x30]=0x0005; A writes 0x0009 @0x30 while B reads 0x30 -> b_rdata=0x0009 (WRITE_FIRST=1) or 0x0005 (WRITE_FIRST=0).
- Reset mid-operation: write 0xAAAA @0x40, assert rst at sweep ptr=100 -> sweep restarts at 0, busy high 256 more cycles. Then mem[0x40]=0, accesses during busy are ignored, rvalid=0.
- Parity (DPRAM_PARITY_EN): write 0x0003 @0x50, force the stored parity bit flipped, read -> a_perr=1 with a_rvalid. An unmodified word -> perr=0.
